// File: rtl/err_compute_if.sv
//==============================================================================
// Module      : err_compute_if
// Description : Conversion handshake between the steering-error engine and
//               the A2D front end.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface err_compute_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );
endinterface

`default_nettype wire

// File: rtl/err_compute.sv
//==============================================================================
// Module      : err_compute
// Description : Sequences an 8-channel A2D round and produces a weighted,
//               saturated 11-bit steering error plus a line-present flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module err_compute #(
    parameter logic [11:0] LINE_THRES = 12'h200
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        strt_rnd,
    err_compute_if.master    a2d,
    output logic [10:0]      err_sat,
    output logic             err_vld,
    output logic             line_present
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic signed [16:0] r_acc;
    logic [2:0]         r_idx;
    logic               r_line;
    logic               r_strt_cnv;
    logic [2:0]         r_chnnl;
    logic [10:0]        r_err_sat;
    logic               r_err_vld;
    logic               r_line_present;

    logic               w_clr;
    logic               w_fire;
    logic               w_acc_en;
    logic               w_idx_inc;
    logic               w_finish;

    logic signed [16:0] w_res_ext;
    logic signed [16:0] w_weighted;
    logic signed [16:0] w_acc_nxt;
    logic [10:0]        w_sat;
    logic               w_hit;

    // Even channels add, odd channels subtract; idx[2:1] selects the power-of-two weight.
    assign w_res_ext  = {5'd0, a2d.res};
    assign w_weighted = w_res_ext <<< r_idx[2:1];
    assign w_acc_nxt  = r_idx[0] ? (r_acc - w_weighted) : (r_acc + w_weighted);
    assign w_hit      = (a2d.res >= LINE_THRES);

    always_comb begin
        w_sat = w_acc_nxt[10:0];
        if (w_acc_nxt > 17'sd1023) begin
            w_sat = 11'h3FF;
        end else if (w_acc_nxt < -17'sd1024) begin
            w_sat = 11'h400;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_fire      = 1'b0;
        w_acc_en    = 1'b0;
        w_idx_inc   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (strt_rnd) begin
                    w_clr       = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_fire      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (a2d.cnv_cmplt) begin
                    w_acc_en = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_finish    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = CONV;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result registers load on the edge entering DONE so they are visible during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_idx          <= '0;
            r_line         <= 1'b0;
            r_strt_cnv     <= 1'b0;
            r_chnnl        <= '0;
            r_err_sat      <= '0;
            r_err_vld      <= 1'b0;
            r_line_present <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_strt_cnv <= w_fire;
            r_err_vld  <= w_finish;
            if (w_fire) begin
                r_chnnl <= r_idx;
            end
            if (w_clr) begin
                r_acc  <= '0;
                r_idx  <= '0;
                r_line <= 1'b0;
            end
            if (w_acc_en) begin
                r_acc  <= w_acc_nxt;
                r_line <= r_line | w_hit;
            end
            if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_finish) begin
                r_err_sat      <= w_sat;
                r_line_present <= r_line | w_hit;
            end
        end
    end

    assign a2d.strt_cnv = r_strt_cnv;
    assign a2d.chnnl    = r_chnnl;
    assign err_sat      = r_err_sat;
    assign err_vld      = r_err_vld;
    assign line_present = r_line_present;

endmodule

`default_nettype wire

// File: tb/tb_err_compute.sv
//==============================================================================
// Module      : tb_err_compute
// Description : Self-checking bench for err_compute with an A2D model and an
//               arithmetic reference of the weighted steering error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_err_compute;

    localparam int TCONV = 4;

    logic        clk;
    logic        rst_n;
    logic        strt_rnd;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        line_present;
    logic        m_cmplt;
    logic        stray;
    logic [11:0] m_res;

    err_compute_if a2d ();

    assign a2d.cnv_cmplt = m_cmplt | stray;
    assign a2d.res       = m_res;

    err_compute #(.LINE_THRES(12'h200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strt_rnd     (strt_rnd),
        .a2d          (a2d),
        .err_sat      (err_sat),
        .err_vld      (err_vld),
        .line_present (line_present)
    );

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [11:0] vals [8];
    int          cnv_cnt = 0;
    int          chseq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed sum of res*(+/-2^(ch/2)), sign set by channel parity.
    function automatic int ref_acc();
        int s = 0;
        for (int ch = 0; ch < 8; ch++) begin
            int w = (1 << (ch / 2)) * int'(vals[ch]);
            if (ch % 2 == 1) s -= w;
            else             s += w;
        end
        return s;
    endfunction

    function automatic logic [10:0] ref_sat();
        int s = ref_acc();
        logic [31:0] v;
        if (s > 1023)  return 11'h3FF;
        if (s < -1024) return 11'h400;
        v = s;
        return v[10:0];
    endfunction

    function automatic logic ref_line();
        for (int ch = 0; ch < 8; ch++) begin
            if (vals[ch] >= 12'h200) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A2D model: answers each strt_cnv after TCONV cycles; abandons the conversion on reset.
    initial begin
        int   mch;
        logic abort;
        m_cmplt = 1'b0;
        m_res   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && a2d.strt_cnv) begin
                mch = int'(a2d.chnnl);
                cnv_cnt++;
                chseq.push_back(mch);
                abort = 1'b0;
                for (int k = 0; k < TCONV; k++) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort) begin
                    chk("chnnl_held", {29'd0, a2d.chnnl}, mch);
                    m_res   = vals[mch];
                    m_cmplt = 1'b1;
                    @(negedge clk);
                    m_cmplt = 1'b0;
                    m_res   = '0;
                end
            end
        end
    end

    task automatic run_round(input string tag, input logic robust);
        int          lat;
        logic        pulsed;
        logic [23:0] seq;
        logic [10:0] exp_sat;
        logic        exp_line;
        exp_sat  = ref_sat();
        exp_line = ref_line();
        cnv_cnt  = 0;
        chseq.delete();
        pulsed   = 1'b0;
        if (robust) begin
            @(negedge clk);
            stray = 1'b1;
            @(negedge clk);
            stray = 1'b0;
        end
        @(negedge clk);
        strt_rnd = 1'b1;
        @(negedge clk);
        strt_rnd = 1'b0;
        lat = 1;
        while (!err_vld && lat < 300) begin
            @(negedge clk);
            lat++;
            if (robust && !pulsed && cnv_cnt == 4) begin
                strt_rnd = 1'b1;
                pulsed   = 1'b1;
            end else begin
                strt_rnd = 1'b0;
            end
        end
        strt_rnd = 1'b0;
        chk({tag, "_latency"}, lat, 49);
        chk({tag, "_err_sat"}, {21'd0, err_sat}, {21'd0, exp_sat});
        chk({tag, "_line"}, {31'd0, line_present}, {31'd0, exp_line});
        seq = '0;
        foreach (chseq[i]) seq = (seq << 3) | 24'(chseq[i]);
        chk({tag, "_chseq"}, {8'd0, seq}, {8'd0, 24'o01234567});
        @(negedge clk);
        chk({tag, "_vld_pulse"}, {31'd0, err_vld}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2 && robust) stray = 1'b1;
            else                  stray = 1'b0;
            if (err_vld) chk({tag, "_extra_vld"}, 32'd1, 32'd0);
        end
        stray = 1'b0;
        chk({tag, "_cnv_count"}, cnv_cnt, 8);
        chk({tag, "_hold_sat"}, {21'd0, err_sat}, {21'd0, exp_sat});
    endtask

    task automatic set_vals(input logic [11:0] v0, v1, v2, v3, v4, v5, v6, v7);
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        vals[4] = v4; vals[5] = v5; vals[6] = v6; vals[7] = v7;
    endtask

    initial begin
        int bound;
        rst_n    = 1'b0;
        strt_rnd = 1'b0;
        stray    = 1'b0;
        set_vals(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst_err_sat", {21'd0, err_sat}, 32'd0);
            chk("rst_err_vld", {31'd0, err_vld}, 32'd0);
            chk("rst_line", {31'd0, line_present}, 32'd0);
            chk("rst_strt_cnv", {31'd0, a2d.strt_cnv}, 32'd0);
        end

        set_vals(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
        run_round("balanced", 1'b0);
        set_vals(0, 0, 0, 0, 0, 0, 12'hFFF, 0);
        run_round("sat_pos", 1'b0);
        set_vals(0, 0, 0, 0, 0, 0, 0, 12'hFFF);
        run_round("sat_neg", 1'b0);
        set_vals(12'h050, 0, 12'h040, 0, 0, 0, 0, 0);
        run_round("arith_pos", 1'b0);
        set_vals(0, 12'h100, 0, 0, 0, 0, 0, 0);
        run_round("arith_neg", 1'b0);
        set_vals(12'h050, 12'h010, 12'h040, 12'h020, 12'h008, 12'h004, 12'h002, 12'h001);
        run_round("robust", 1'b1);

        // Reset landing in the middle of the channel-4 conversion.
        set_vals(0, 0, 0, 0, 12'hFFF, 0, 0, 12'hFFF);
        cnv_cnt = 0;
        chseq.delete();
        @(negedge clk);
        strt_rnd = 1'b1;
        @(negedge clk);
        strt_rnd = 1'b0;
        bound = 0;
        while (cnv_cnt < 5 && bound < 300) begin
            @(negedge clk);
            bound++;
        end
        chk("midrst_reach_ch4", cnv_cnt, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_err_sat", {21'd0, err_sat}, 32'd0);
        chk("midrst_line", {31'd0, line_present}, 32'd0);
        chk("midrst_err_vld", {31'd0, err_vld}, 32'd0);
        chk("midrst_chnnl", {29'd0, a2d.chnnl}, 32'd0);
        chk("midrst_strt_cnv", {31'd0, a2d.strt_cnv}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TCONV + 4) @(negedge clk);
        chk("postrst_no_vld", {31'd0, err_vld}, 32'd0);
        set_vals(12'h123, 12'h045, 12'h300, 12'h010, 12'h020, 12'h033, 12'h011, 12'h007);
        run_round("postrst", 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int ch = 0; ch < 8; ch++) begin
                case ($urandom_range(0, 3))
                    0:       vals[ch] = 12'h000;
                    1:       vals[ch] = 12'($urandom_range(0, 12'h1FF));
                    2:       vals[ch] = 12'($urandom_range(0, 12'hFFF));
                    default: vals[ch] = 12'hFFF;
                endcase
            end
            run_round($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/err_compute.md
ERR_COMPUTE -- requirements
Module: err_compute

Interface -- parameters
REQ-001 SHALL have parameter LINE_THRES, default 12'h200, minimum raw reading that counts as a sensor seeing the line.

Interface -- ports
REQ-002 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port strt_rnd  input  1  one-cycle pulse requesting one 8-channel measurement round.
REQ-005 SHALL have port strt_cnv  output  1  one-cycle pulse to the A2D interface to start a conversion.
REQ-006 SHALL have port chnnl  output  3  A2D channel select, valid while strt_cnv is high and held until cnv_cmplt.
REQ-007 SHALL have port cnv_cmplt  input  1  one-cycle pulse from the A2D interface, res valid.
REQ-008 SHALL have port res  input  12  unsigned conversion result.
REQ-009 SHALL have port err_sat  output  11  signed saturated steering error, feeds I_term/P_term.
REQ-010 SHALL have port err_vld  output  1  one-cycle pulse, err_sat freshly updated.
REQ-011 SHALL have port line_present  output  1  high when any channel in the last round read >= LINE_THRES.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV, WAIT and DONE.
REQ-013 IDLE: on strt_rnd, the FSM SHALL clear the accumulator, the channel index and the line flag, then go to CONV.
REQ-014 CONV: the FSM SHALL drive strt_cnv=1 for exactly one cycle with chnnl=index, then go to WAIT.
REQ-015 WAIT: the FSM SHALL hold chnnl; on cnv_cmplt it SHALL add weighted res to the accumulator and OR (res>=LINE_THRES) into the line flag. It SHALL then go to DONE if index==7, else increment index and go to CONV.
REQ-016 Channel weights SHALL be: ch0 +1, ch1 -1, ch2 +2, ch3 -2, ch4 +4, ch5 -4, ch6 +8, ch7 -8, implemented as shifts of zero-extended res.
REQ-017 The accumulator SHALL be 17-bit signed, wide enough for +/-61425, and SHALL never overflow.
REQ-018 DONE: err_sat SHALL take the value of the accumulator saturated to 11-bit signed (>1023 gives 0x3FF, <-1024 gives 0x400, otherwise low 11 bits). In the same cycle line_present SHALL take the line flag, err_vld SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-019 err_sat and line_present SHALL hold their values between rounds and change only in DONE.
REQ-020 strt_rnd SHALL be ignored in every state except IDLE; each round SHALL issue exactly 8 conversions, channels 0..7 in order.
REQ-021 cnv_cmplt outside WAIT SHALL be ignored.
REQ-022 Latency SHALL be strt_rnd to err_vld = 8*(2+Tconv)+1 cycles, where Tconv is the cycles from strt_cnv to cnv_cmplt.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting rst_n low at any time, including mid-round, SHALL immediately force the state to IDLE and set err_sat=0, err_vld=0, line_present=0, strt_cnv=0, chnnl=0, accumulator=0 and index=0.
REQ-025 After reset the first strt_rnd SHALL start at channel 0, and no partial-round result SHALL ever appear.

Verification
REQ-026 Reset: rst_n low, then high with no strt_rnd -> err_sat=0x000, err_vld=0, line_present=0, strt_cnv=0 for 20 cycles.
REQ-027 Balanced: A2D model (Tconv=4) returns 0x800 on all channels -> single err_vld pulse 49 cycles after strt_rnd, err_sat=0x000, line_present=1, chnnl sequence 0..7 observed.
REQ-028 Saturation: ch6=0xFFF, others 0 -> err_sat=0x3FF, line_present=1. ch7=0xFFF, others 0 -> err_sat=0x400.
REQ-029 Arithmetic: ch0=0x050, ch2=0x040, others 0 -> err_sat=0x0D0, line_present=0. ch1=0x100, others 0 -> err_sat=0x700 (-256), line_present=0.
REQ-030 Robustness: strt_rnd re-pulsed during WAIT of ch3 and a stray cnv_cmplt in IDLE -> still exactly 8 strt_cnv pulses and one err_vld, result unchanged.
REQ-031 Reset mid-round: rst_n low during ch4 conversion -> all outputs 0 at once; next round starts at chnnl=0 and gives the correct full result.
